// File: rtl/slot_pkg.sv
// Shared types and constants for the multi-reel slot machine: FSM states,
// maximal-length LFSR tap masks and the per-reel power-on seed.
package slot_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SPIN     = 2'd1,
      STOPPING = 2'd2,
      RESULT   = 2'd3
   } state_t;

   // Taps for a right-shifting Fibonacci LFSR: new MSB = ^(value & mask).
   // Each entry encodes a primitive polynomial x^W + sum(x^j for set bit j).
   localparam logic [7:0] TAP_MASK [3:8] = '{8'h03, 8'h03, 8'h05, 8'h03, 8'h03, 8'h1D};

   // Staggered one-hot seeds so the reels never start out in step.
   function automatic logic [7:0] seed(input int i, input int w);
      int pos;
      pos  = (((w - 2 - i) % w) + w) % w;
      seed = 8'h01 << pos;
   endfunction

endpackage

// File: rtl/slot_lfsr.sv
// One reel: a W-bit maximal-length Fibonacci LFSR that steps when adv is high.
module slot_lfsr
   import slot_pkg::*;
#(
   parameter int         W    = 4,
   parameter logic [7:0] SEED = 8'h04
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         adv,
   output logic [W-1:0] value
);

   localparam logic [7:0]   MASK_FULL = TAP_MASK[W];
   localparam logic [W-1:0] MASK      = MASK_FULL[W-1:0];
   localparam logic [W-1:0] SEED_W    = SEED[W-1:0];

   // Shift register: seed on reset, one right shift per advance.
   always_ff @(posedge clock) begin
      if (reset) begin
         value <= SEED_W;
      end else if (adv) begin
         value <= {^(value & MASK), value[W-1:1]};
      end else begin
         value <= value;
      end
   end

endmodule

// File: rtl/slot_machine_reels.sv
// Multi-reel slot machine: start/stop FSM, staggered reel freezing and
// registered win/pair detection on top of per-reel LFSRs.
module slot_machine_reels
   import slot_pkg::*;
#(
   parameter int NUM_REELS = 3,
   parameter int REEL_W    = 4,
   parameter int STOP_GAP  = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          stop,
   output logic [NUM_REELS*REEL_W-1:0]   reels,
   output logic [NUM_REELS-1:0]          stopped,
   output logic                          busy,
   output logic                          done,
   output logic                          win,
   output logic                          pair
);

   localparam int GAP_W = $clog2(STOP_GAP + 1);
   localparam int IDX_W = (NUM_REELS > 1) ? $clog2(NUM_REELS) : 1;
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(STOP_GAP - 1);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REELS - 1);

   state_t               state_r, state_s;
   logic [GAP_W-1:0]     gap_r, gap_s;
   logic [IDX_W-1:0]     idx_r, idx_s;
   logic [NUM_REELS-1:0] stopped_s, freeze_s, adv_s;
   logic                 win_s, pair_s, all_eq_s, any_pair_s;
   logic [REEL_W-1:0]    reel_val [NUM_REELS];

   for (genvar i = 0; i < NUM_REELS; i++) begin : g_reel
      slot_lfsr #(
         .W    (REEL_W),
         .SEED (seed(i, REEL_W))
      ) u_lfsr (
         .clock (clock),
         .reset (reset),
         .adv   (adv_s[i]),
         .value (reel_val[i])
      );
      assign reels[i*REEL_W +: REEL_W] = reel_val[i];
   end

   // Equality over the current reel values; frozen reels already hold their final symbols.
   always_comb begin
      all_eq_s   = 1'b1;
      any_pair_s = 1'b0;
      for (int i = 0; i < NUM_REELS; i++) begin
         all_eq_s = all_eq_s & (reel_val[i] == reel_val[0]);
         for (int j = i + 1; j < NUM_REELS; j++) begin
            any_pair_s = any_pair_s | (reel_val[i] == reel_val[j]);
         end
      end
   end

   // Next-state, freeze schedule and per-reel advance enables.
   always_comb begin
      state_s   = state_r;
      gap_s     = gap_r;
      idx_s     = idx_r;
      freeze_s  = '0;
      stopped_s = stopped;
      win_s     = win;
      pair_s    = pair;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s   = SPIN;
               stopped_s = '0;
               win_s     = 1'b0;
               pair_s    = 1'b0;
               idx_s     = '0;
            end else begin
               state_s = IDLE;
            end
         end
         SPIN: begin
            if (stop) begin
               freeze_s[0] = 1'b1;
               gap_s       = GAP_RELOAD;
               idx_s       = IDX_W'(1);
               state_s     = (NUM_REELS == 1) ? RESULT : STOPPING;
            end else begin
               state_s = SPIN;
            end
         end
         STOPPING: begin
            if (gap_r == GAP_W'(0)) begin
               freeze_s[idx_r] = 1'b1;
               gap_s           = GAP_RELOAD;
               if (idx_r == LAST_IDX) begin
                  state_s = RESULT;
               end else begin
                  idx_s = idx_r + IDX_W'(1);
               end
            end else begin
               gap_s = gap_r - GAP_W'(1);
            end
         end
         RESULT:  state_s = IDLE;
         default: state_s = IDLE;
      endcase
      stopped_s = stopped_s | freeze_s;
      // Only SPIN/STOPPING can lead into RESULT, so this is the entry edge.
      if (state_s == RESULT) begin
         win_s  = all_eq_s;
         pair_s = any_pair_s;
      end else begin
         win_s  = win_s;
         pair_s = pair_s;
      end
      for (int i = 0; i < NUM_REELS; i++) begin
         adv_s[i] = ((state_r == SPIN) || (state_r == STOPPING)) & ~stopped[i] & ~freeze_s[i];
      end
   end

   // Control and result registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
         gap_r   <= '0;
         idx_r   <= '0;
         stopped <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         win     <= 1'b0;
         pair    <= 1'b0;
      end else begin
         state_r <= state_s;
         gap_r   <= gap_s;
         idx_r   <= idx_s;
         stopped <= stopped_s;
         busy    <= (state_s != IDLE);
         done    <= (state_s == RESULT);
         win     <= win_s;
         pair    <= pair_s;
      end
   end

endmodule

// File: tb/tb_slot_machine_reels.sv
// Directed bench: three shared-stimulus instances (3 reels gap 8, 3 reels gap 14,
// 2 reels gap 14) checked against hand-computed reel values and freeze schedules.
module tb_slot_machine_reels;

   logic clock, reset, start, stop;
   logic [11:0] a_reels, b_reels;
   logic [7:0]  c_reels;
   logic [2:0]  a_stopped, b_stopped;
   logic [1:0]  c_stopped;
   logic a_busy, a_done, a_win, a_pair;
   logic b_busy, b_done, b_win, b_pair;
   logic c_busy, c_done, c_win, c_pair;
   int checks = 0;
   int errors = 0;

   slot_machine_reels dut_a (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .reels(a_reels),
      .stopped(a_stopped), .busy(a_busy), .done(a_done), .win(a_win), .pair(a_pair));

   slot_machine_reels #(.NUM_REELS(3), .REEL_W(4), .STOP_GAP(14)) dut_b (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .reels(b_reels),
      .stopped(b_stopped), .busy(b_busy), .done(b_done), .win(b_win), .pair(b_pair));

   slot_machine_reels #(.NUM_REELS(2), .REEL_W(4), .STOP_GAP(14)) dut_c (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .reels(c_reels),
      .stopped(c_stopped), .busy(c_busy), .done(c_done), .win(c_win), .pair(c_pair));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; stop = 1'b0;
      tick(); tick();
      reset = 1'b0;
      checks++; if (a_reels !== 12'h124) begin errors++; $display("FAIL reset_reels_a got %h exp 124", a_reels); end
      checks++; if (a_stopped !== 3'b000) begin errors++; $display("FAIL reset_stopped_a got %b exp 000", a_stopped); end
      checks++; if ({a_busy, a_done, a_win, a_pair} !== 4'b0000) begin errors++; $display("FAIL reset_flags_a got %b exp 0000", {a_busy, a_done, a_win, a_pair}); end
      checks++; if (b_reels !== 12'h124) begin errors++; $display("FAIL reset_reels_b got %h exp 124", b_reels); end
      checks++; if (c_reels !== 8'h24) begin errors++; $display("FAIL reset_reels_c got %h exp 24", c_reels); end
   endtask

   task automatic test_step();
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (a_reels !== 12'h124 || a_busy !== 1'b1) begin errors++; $display("FAIL step_start got %h/%b exp 124/1", a_reels, a_busy); end
      tick();
      checks++; if (a_reels !== 12'h892) begin errors++; $display("FAIL step_1_a got %h exp 892", a_reels); end
      checks++; if (c_reels !== 8'h92) begin errors++; $display("FAIL step_1_c got %h exp 92", c_reels); end
      tick();
      checks++; if (a_reels !== 12'h4C9) begin errors++; $display("FAIL step_2_a got %h exp 4c9", a_reels); end
      stop = 1'b1; tick(); stop = 1'b0;
      checks++; if (a_stopped !== 3'b001 || a_busy !== 1'b1) begin errors++; $display("FAIL step_stop got %b/%b exp 001/1", a_stopped, a_busy); end
      checks++; if (c_stopped !== 2'b01) begin errors++; $display("FAIL step_stop_c got %b exp 01", c_stopped); end
      tick(); tick();
      // Reset mid-STOPPING, with start asserted alongside to show reset dominates.
      reset = 1'b1; start = 1'b1; tick(); reset = 1'b0; start = 1'b0;
      checks++; if (a_reels !== 12'h124 || a_stopped !== 3'b000 || a_busy !== 1'b0) begin errors++; $display("FAIL midreset_a got %h/%b/%b exp 124/000/0", a_reels, a_stopped, a_busy); end
      checks++; if (b_reels !== 12'h124 || c_reels !== 8'h24) begin errors++; $display("FAIL midreset_bc got %h/%h exp 124/24", b_reels, c_reels); end
      tick(); tick();
      checks++; if (a_reels !== 12'h124 || a_busy !== 1'b0) begin errors++; $display("FAIL midreset_idle got %h/%b exp 124/0", a_reels, a_busy); end
   endtask

   task automatic test_pair();
      logic [2:0] ea, eb;
      logic [1:0] ec;
      start = 1'b1; tick(); start = 1'b0;
      stop = 1'b1; tick(); stop = 1'b0;
      for (int n = 1; n <= 32; n++) begin
         if (n > 1) tick();
         ea = {n >= 17, n >= 9, 1'b1};
         eb = {n >= 29, n >= 15, 1'b1};
         ec = {n >= 15, 1'b1};
         checks++; if ({a_stopped, a_busy, a_done} !== {ea, n <= 17, n == 17}) begin errors++; $display("FAIL pair_sched_a n=%0d got %b exp %b", n, {a_stopped, a_busy, a_done}, {ea, n <= 17, n == 17}); end
         checks++; if ({b_stopped, b_busy, b_done} !== {eb, n <= 29, n == 29}) begin errors++; $display("FAIL pair_sched_b n=%0d got %b exp %b", n, {b_stopped, b_busy, b_done}, {eb, n <= 29, n == 29}); end
         checks++; if ({c_stopped, c_busy, c_done} !== {ec, n <= 15, n == 15}) begin errors++; $display("FAIL pair_sched_c n=%0d got %b exp %b", n, {c_stopped, c_busy, c_done}, {ec, n <= 15, n == 15}); end
         if (n == 15) begin
            checks++; if ({c_reels, c_win, c_pair} !== {8'h44, 2'b11}) begin errors++; $display("FAIL win_c got %h/%b%b exp 44/11", c_reels, c_win, c_pair); end
         end
         if (n == 17) begin
            checks++; if ({a_reels, a_win, a_pair} !== {12'h8E4, 2'b00}) begin errors++; $display("FAIL nopair_a got %h/%b%b exp 8e4/00", a_reels, a_win, a_pair); end
         end
         if (n == 29) begin
            checks++; if ({b_reels, b_win, b_pair} !== {12'h744, 2'b01}) begin errors++; $display("FAIL pair_b got %h/%b%b exp 744/01", b_reels, b_win, b_pair); end
         end
      end
   endtask

   task automatic test_ignored();
      logic [2:0] ea, eb;
      logic [1:0] ec;
      reset = 1'b1; tick(); reset = 1'b0;
      stop = 1'b1; tick(); stop = 1'b0;
      checks++; if ({a_busy, a_stopped, a_reels} !== {1'b0, 3'b000, 12'h124}) begin errors++; $display("FAIL stop_in_idle got %b/%b/%h exp 0/000/124", a_busy, a_stopped, a_reels); end
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      checks++; if ({a_busy, a_stopped, b_stopped, c_stopped, a_reels} !== {1'b1, 8'h00, 12'h124}) begin errors++; $display("FAIL start_stop_idle got %b/%b/%h exp 1/0/124", a_busy, a_stopped, a_reels); end
      tick();
      checks++; if ({a_stopped, a_reels} !== {3'b000, 12'h892}) begin errors++; $display("FAIL spin_1 got %b/%h exp 000/892", a_stopped, a_reels); end
      start = 1'b1; tick(); start = 1'b0;
      checks++; if ({a_busy, a_stopped, a_reels} !== {1'b1, 3'b000, 12'h4C9}) begin errors++; $display("FAIL start_in_spin got %b/%b/%h exp 1/000/4c9", a_busy, a_stopped, a_reels); end
      tick();
      stop = 1'b1; tick(); stop = 1'b0;
      for (int m = 0; m <= 30; m++) begin
         if (m > 0) begin
            stop  = (m == 3) || (m == 5);
            start = (m == 4);
            tick();
            stop  = 1'b0;
            start = 1'b0;
         end
         ea = {m >= 16, m >= 8, 1'b1};
         eb = {m >= 28, m >= 14, 1'b1};
         ec = {m >= 14, 1'b1};
         checks++; if ({a_stopped, a_busy, a_done} !== {ea, m <= 16, m == 16}) begin errors++; $display("FAIL ign_sched_a m=%0d got %b exp %b", m, {a_stopped, a_busy, a_done}, {ea, m <= 16, m == 16}); end
         checks++; if ({b_stopped, b_busy, b_done} !== {eb, m <= 28, m == 28}) begin errors++; $display("FAIL ign_sched_b m=%0d got %b exp %b", m, {b_stopped, b_busy, b_done}, {eb, m <= 28, m == 28}); end
         checks++; if ({c_stopped, c_busy, c_done} !== {ec, m <= 14, m == 14}) begin errors++; $display("FAIL ign_sched_c m=%0d got %b exp %b", m, {c_stopped, c_busy, c_done}, {ec, m <= 14, m == 14}); end
      end
      checks++; if ({a_reels, a_win, a_pair} !== {12'h93C, 2'b00}) begin errors++; $display("FAIL ign_result_a got %h/%b%b exp 93c/00", a_reels, a_win, a_pair); end
      checks++; if ({b_reels, b_win, b_pair} !== {12'h8CC, 2'b01}) begin errors++; $display("FAIL ign_result_b got %h/%b%b exp 8cc/01", b_reels, b_win, b_pair); end
      checks++; if ({c_reels, c_win, c_pair} !== {8'hCC, 2'b11}) begin errors++; $display("FAIL ign_result_c got %h/%b%b exp cc/11", c_reels, c_win, c_pair); end
   endtask

   task automatic test_hold();
      repeat (20) tick();
      checks++; if ({a_reels, a_win, a_pair, a_busy, a_done} !== {12'h93C, 4'b0000}) begin errors++; $display("FAIL hold_a got %h/%b exp 93c/0000", a_reels, {a_win, a_pair, a_busy, a_done}); end
      checks++; if ({b_reels, b_win, b_pair, b_stopped} !== {12'h8CC, 2'b01, 3'b111}) begin errors++; $display("FAIL hold_b got %h/%b%b/%b exp 8cc/01/111", b_reels, b_win, b_pair, b_stopped); end
      checks++; if ({c_reels, c_win, c_pair} !== {8'hCC, 2'b11}) begin errors++; $display("FAIL hold_c got %h/%b%b exp cc/11", c_reels, c_win, c_pair); end
      start = 1'b1; tick(); start = 1'b0;
      checks++; if ({b_reels, b_win, b_pair, b_stopped, b_busy} !== {12'h8CC, 2'b00, 3'b000, 1'b1}) begin errors++; $display("FAIL restart_b got %h/%b%b/%b/%b exp 8cc/00/000/1", b_reels, b_win, b_pair, b_stopped, b_busy); end
      checks++; if ({c_win, c_pair, c_stopped} !== 4'b0000) begin errors++; $display("FAIL restart_c got %b exp 0000", {c_win, c_pair, c_stopped}); end
      tick();
      checks++; if (b_reels !== 12'h466) begin errors++; $display("FAIL restart_step_b got %h exp 466", b_reels); end
      reset = 1'b1; tick(); reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0;
      test_reset();
      test_step();
      test_pair();
      test_ignored();
      test_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
